regfile_multiport: RTL
======================

REGFILE_MULTIPORT -- requirements
Module: regfile_multiport

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning register width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 5, meaning register index width; depth is 2**ADDR_W.
REQ-003 The block SHALL have parameter NUM_RD, default 2, meaning number of independent read ports (1..4).
REQ-004 The block SHALL have parameter ZERO_REG, default 1, meaning that when it is 1, register 0 reads as zero and ignores writes.
REQ-005 The block SHALL have parameter BYPASS, default 1, meaning that when it is 1, same-cycle write data forwards to a matching read.
REQ-006 The block SHALL have port clock, input, 1 bit: the single clock, rising-edge active.
REQ-007 The block SHALL have port ctrl_reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 The block SHALL have port ctrl_writeEnable, input, 1 bit: write strobe.
REQ-009 The block SHALL have port ctrl_writeReg, input, ADDR_W bits: write index.
REQ-010 The block SHALL have port data_writeReg, input, DATA_W bits: write data.
REQ-011 The block SHALL have port ctrl_readEn, input, NUM_RD bits: per-port read request; bit p belongs to port p.
REQ-012 The block SHALL have port ctrl_readReg, input, NUM_RD*ADDR_W bits: read indices; port p occupies bits [p*ADDR_W +: ADDR_W].
REQ-013 The block SHALL have port data_readReg, output, NUM_RD*DATA_W bits: read data; port p occupies bits [p*DATA_W +: DATA_W].
REQ-014 The block SHALL have port data_readValid, output, NUM_RD bits: per-port read-data valid.
REQ-015 The block SHALL have port write_count, output, 16 bits: count of accepted writes since reset.

Function
REQ-016 The block SHALL store 2**ADDR_W registers of DATA_W bits, written on the rising clock edge when ctrl_writeEnable=1.
REQ-017 The block SHALL discard a write to index 0 when ZERO_REG=1; such a write SHALL NOT increment write_count.
REQ-018 The block SHALL register reads: with ctrl_readEn[p]=1 at edge N, data_readReg port p and data_readValid[p]=1 SHALL appear after edge N (one-cycle latency).
REQ-019 The block SHALL, when ctrl_readEn[p]=0 at an edge, hold data_readReg port p at its previous value and drive data_readValid[p]=0.
REQ-020 The block SHALL, when BYPASS=1 and a read at edge N matches the write index at edge N, return the new data_writeReg (write-first).
REQ-021 The block SHALL, when BYPASS=0 under the same condition, return the pre-write register contents (read-first).
REQ-022 The block SHALL return 0 for any read of index 0 when ZERO_REG=1, regardless of BYPASS.
REQ-023 The block SHALL let all NUM_RD ports read any index, including the same index, in the same cycle with no arbitration or stall.
REQ-024 The block SHALL increment write_count by 1 per accepted write; it SHALL wrap from 16'hFFFF to 0.
REQ-025 The block SHALL drive outputs only from flops; no tristate or internal bus SHALL be used.

Reset
REQ-026 The block SHALL clear, on ctrl_reset_n=0 and independently of clock, all registers, data_readReg, data_readValid and write_count to 0.
REQ-027 The block SHALL ignore writes and reads while ctrl_reset_n=0; the first edge after deassertion SHALL operate normally.
REQ-028 The block SHALL apply reset immediately when asserted mid-operation; an in-flight read SHALL produce data_readValid=0 and no stale data.

Verification
REQ-029 Write 32'hDEADBEEF to r5, then read r5 on port 0 next cycle -> one cycle later data_readReg[31:0]=32'hDEADBEEF and data_readValid[0]=1; write_count=1.
REQ-030 With BYPASS=1, write 32'h1234 to r7 and read r7 on port 1 at the same edge -> port 1 returns 32'h1234; with BYPASS=0 it returns the old value 0.
REQ-031 With ZERO_REG=1, write 32'hFFFFFFFF to r0, then read r0 on both ports -> both return 0 and write_count is unchanged.
REQ-032 Write r3=32'hA and r4=32'hB, then read r3 on port 0 and r4 on port 1 in one cycle -> 32'hA and 32'hB respectively, both valids=1.
REQ-033 Assert ctrl_reset_n=0 between clock edges after loading r9=32'h55 -> all outputs are 0 immediately; a subsequent read of r9 returns 0.
REQ-034 Perform 65536 writes to r1 -> write_count wraps to 0; r1 holds the last data written.

Source files
------------

// File: rtl/regfile_multiport.sv
// Multi-ported register file: one write port, NUM_RD registered read ports,
// optional hard-wired zero register and optional write-to-read forwarding.

// One read port: selects the source for its index and registers it.
module regfile_rd_port #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                                   clock,
    input  logic                                   ctrl_reset_n,
    input  logic                                   rd_en,
    input  logic [ADDR_W-1:0]                      rd_addr,
    input  logic [(1<<ADDR_W)-1:0][DATA_W-1:0]     regs,
    input  logic                                   wr_acc,
    input  logic [ADDR_W-1:0]                      wr_addr,
    input  logic [DATA_W-1:0]                      wr_data,
    output logic [DATA_W-1:0]                      rd_data,
    output logic                                   rd_valid
);

    logic [DATA_W-1:0] rd_next;
    logic              zero_hit;
    logic              byp_hit;

    assign zero_hit = (ZERO_REG != 0) && (rd_addr == '0);
    assign byp_hit  = (BYPASS != 0) && wr_acc && (wr_addr == rd_addr);

    // Source select: zero register wins, then same-cycle write data, then storage.
    always_comb begin
        rd_next = regs[rd_addr];
        if (zero_hit)
            rd_next = '0;
        else if (byp_hit)
            rd_next = wr_data;
    end

    // Output register: load on request, otherwise hold data and drop valid.
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en)
                rd_data <= rd_next;
        end
    end

endmodule

module regfile_multiport #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                       clock,
    input  logic                       ctrl_reset_n,
    input  logic                       ctrl_writeEnable,
    input  logic [ADDR_W-1:0]          ctrl_writeReg,
    input  logic [DATA_W-1:0]          data_writeReg,
    input  logic [NUM_RD-1:0]          ctrl_readEn,
    input  logic [NUM_RD*ADDR_W-1:0]   ctrl_readReg,
    output logic [NUM_RD*DATA_W-1:0]   data_readReg,
    output logic [NUM_RD-1:0]          data_readValid,
    output logic [15:0]                write_count
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0][DATA_W-1:0] regs;
    logic                         wr_acc;

    // A write to the hard-wired zero register is dropped entirely (not counted).
    assign wr_acc = ctrl_writeEnable &&
                    !((ZERO_REG != 0) && (ctrl_writeReg == '0));

    // Storage array; entry 0 simply never loads when it is the zero register.
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n)
            regs <= '0;
        else if (wr_acc)
            regs[ctrl_writeReg] <= data_writeReg;
    end

    // Accepted-write counter; natural 16-bit wrap.
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n)
            write_count <= '0;
        else if (wr_acc)
            write_count <= write_count + 16'd1;
    end

    // Independent read ports, no arbitration between them.
    genvar p;
    generate
        for (p = 0; p < NUM_RD; p++) begin : g_rd
            regfile_rd_port #(
                .DATA_W   (DATA_W),
                .ADDR_W   (ADDR_W),
                .ZERO_REG (ZERO_REG),
                .BYPASS   (BYPASS)
            ) u_rd (
                .clock        (clock),
                .ctrl_reset_n (ctrl_reset_n),
                .rd_en        (ctrl_readEn[p]),
                .rd_addr      (ctrl_readReg[p*ADDR_W +: ADDR_W]),
                .regs         (regs),
                .wr_acc       (wr_acc),
                .wr_addr      (ctrl_writeReg),
                .wr_data      (data_writeReg),
                .rd_data      (data_readReg[p*DATA_W +: DATA_W]),
                .rd_valid     (data_readValid[p])
            );
        end
    endgenerate

endmodule
